// File: rtl/uart_reg_responder_pkg.sv
// Shared definitions for the UART register responder and its tx handshake:
// state encodings, command field positions, reply defaults and bit timing.
package uart_reg_responder_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   localparam int WR_BIT  = 7;
   localparam int RSV_MSB = 6;
   localparam int RSV_LSB = 4;

   localparam logic [DATA_W-1:0] ACK_DEFAULT = 8'hA5;
   localparam logic [DATA_W-1:0] NAK_DEFAULT = 8'h5A;

   // Same clocks-per-bit rounding the rx/tx engines use.
   function automatic int unsigned clk_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_reg_responder_tx.sv
// Start/busy handshake toward a UART transmitter: accepts one byte request,
// issues a single tx_start when the line is free and holds tx_data until done.
module uart_tx_handshake
   import uart_reg_responder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [DATA_W-1:0] req_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              active
);

   state_t state, state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         tx_data <= '0;
      end else begin
         state <= state_nxt;
         if (req && state == S_IDLE) tx_data <= req_data;
      end
   end

   // tx_start is combinational so a free transmitter starts one cycle after req.
   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      case (state)
         S_IDLE:    if (req) state_nxt = S_SEND;
         S_SEND: begin
            if (!tx_busy) begin
               tx_start  = 1'b1;
               state_nxt = S_WAIT_HI;
            end
         end
         S_WAIT_HI: if (tx_busy) state_nxt = S_WAIT_LO;
         S_WAIT_LO: if (!tx_busy) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   assign active = (state != S_IDLE);

endmodule

// File: rtl/uart_reg_responder.sv
// Byte-level read/write command responder between UART rx/tx engines and a
// bank of 8 control (driven) and 8 status (input) registers.
module uart_reg_responder
   import uart_reg_responder_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = 100_000_000,
   parameter int unsigned BAUD          = 10_000,
   parameter int unsigned TIMEOUT_BYTES = 4,
   parameter logic [7:0]  ACK_BYTE      = ACK_DEFAULT,
   parameter logic [7:0]  NAK_BYTE      = NAK_DEFAULT,
   parameter logic [63:0] CTRL_RESET    = 64'h0
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic [63:0] ctrl_regs,
   input  logic [63:0] status_in,
   output logic        wr_strobe,
   output logic [2:0]  wr_addr,
   output logic        err_overrun,
   output logic        err_timeout
);

   localparam logic [31:0] TMO_MAX =
      32'(TIMEOUT_BYTES * 10 * clk_per_bit(CLK_FREQ, BAUD) - 1);

   // Only S_IDLE and S_WAIT_DATA live here; reply states live in the handshake.
   state_t      state, state_nxt;
   logic [3:0]  addr;
   logic [31:0] tmo_cnt;
   logic        hs_active, reply_req, do_write, tmo_fire;
   logic [7:0]  reply;
   logic [63:0] rd_bank;

   assign rd_bank = rx_data[3] ? status_in : ctrl_regs;

   always_comb begin
      state_nxt = state;
      reply_req = 1'b0;
      reply     = NAK_BYTE;
      do_write  = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid && !hs_active) begin
               if (rx_data[RSV_MSB:RSV_LSB] != '0) begin
                  reply_req = 1'b1;
               end else if (!rx_data[WR_BIT]) begin
                  reply_req = 1'b1;
                  reply     = rd_bank[{rx_data[2:0], 3'b000} +: 8];
               end else begin
                  state_nxt = S_WAIT_DATA;
               end
            end
         end
         S_WAIT_DATA: begin
            // A data byte on the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
               reply_req = 1'b1;
               state_nxt = S_IDLE;
               if (!addr[3]) begin
                  do_write = 1'b1;
                  reply    = ACK_BYTE;
               end
            end else if (tmo_cnt == TMO_MAX) begin
               tmo_fire  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         addr        <= '0;
         tmo_cnt     <= '0;
         ctrl_regs   <= CTRL_RESET;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_strobe <= do_write;
         if (state == S_IDLE && rx_valid) addr <= rx_data[3:0];
         if (state == S_WAIT_DATA) begin
            if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 32'd1;
         end else begin
            tmo_cnt <= '0;
         end
         if (do_write) begin
            ctrl_regs[{addr[2:0], 3'b000} +: 8] <= rx_data;
            wr_addr                             <= addr[2:0];
         end
         if (rx_valid && hs_active) err_overrun <= 1'b1;
         if (tmo_fire) err_timeout <= 1'b1;
      end
   end

   uart_tx_handshake u_tx_hs (
      .clk      (clk),
      .rst      (rst),
      .req      (reply_req),
      .req_data (reply),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .active   (hs_active)
   );

endmodule
